// File: rtl/cdc_hs_pkg.sv
// Shared types for the 4-phase req/ack crossing controllers.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2,
    ABORT   = 2'd3
  } hs_state_t;

  localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/cdc_sync_ff.sv
// Parametric multi-flop synchronizer chain; shared by the source (ack) and destination (req) sides.
module cdc_sync_ff #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx_ctrl.sv
// Source side of a 4-phase req/ack crossing: holds the payload stable while req/ack
// sequence through a synchronizer, counts completions and aborts stalled phases.
module cdc_hs_tx_ctrl
  import cdc_hs_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  req_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ack_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic [XFER_CNT_W-1:0] xfer_cnt_o
);

  // A disabled timeout still needs a legal 1-bit counter; it is simply never advanced.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  hs_state_t             state_q, state_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  to_q, to_d;
  logic [CNT_W-1:0]      phase_q, phase_d;
  logic [XFER_CNT_W-1:0] xfer_q, xfer_d;
  logic                  ack_s;
  logic                  timed_out;

  cdc_sync_ff #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1)
  ) u_ack_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (ack_i),
    .q_o   (ack_s)
  );

  assign timed_out = TO_EN && (phase_q == TO_LIM);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    to_d    = 1'b0;
    phase_d = phase_q;
    xfer_d  = xfer_q;
    case (state_q)
      IDLE: begin
        if (s_valid_i && s_ready_o) begin
          data_d  = s_data_i;
          req_d   = 1'b1;
          phase_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // Exit condition is checked first so a late ack beats the timeout.
        if (ack_s) begin
          req_d   = 1'b0;
          phase_d = '0;
          state_d = RELEASE;
        end else if (timed_out) begin
          req_d   = 1'b0;
          to_d    = 1'b1;
          state_d = ABORT;
        end else if (TO_EN) begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          xfer_d  = xfer_q + XFER_CNT_W'(1);
          state_d = IDLE;
        end else if (timed_out) begin
          to_d    = 1'b1;
          state_d = ABORT;
        end else if (TO_EN) begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      ABORT: begin
        req_d = 1'b0;
        if (!ack_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      phase_q <= '0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      to_q    <= to_d;
      phase_q <= phase_d;
      xfer_q  <= xfer_d;
    end
  end

  // Holding off while a stale ack is still visible keeps a new req from aliasing the old one.
  assign s_ready_o  = (state_q == IDLE) && !ack_s;
  assign req_o      = req_q;
  assign data_o     = data_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign timeout_o  = to_q;
  assign xfer_cnt_o = xfer_q;

endmodule
